// File: rtl/mem_access_stage.sv
// Data-memory access stage between the EX_MEM and MEM_WB pipeline registers.
// Issues loads/stores to a variable-latency data memory over a req/ack
// handshake, supports byte/half/word sizes, stalls the upstream pipeline while
// an access is outstanding, and produces the write-back value plus a
// bubble-qualified RegWrite for MEM_WB.
//
// Ports:
//   Clk, Rst                 clock, synchronous active-low reset
//   EX_MEM_*                 instruction fields from the EX_MEM register
//   MemReq/MemWe/MemAddr/
//   MemWData/MemBe           request side of the data-memory handshake
//   MemAck/MemRData          completion and read data from the memory
//   MemoryToRegisterMux      write-back value to MEM_WB
//   MEM_RegWrite             RegWrite to MEM_WB, 0 on bubbles and faults
//   Stall                    freeze the upstream pipeline this cycle
//   MisalignExc/BusErr       one-cycle misaligned-access / timeout flags
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] EX_MEM_ALUResult,
  input  logic [31:0] EX_MEM_WriteData,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemWrite,
  input  logic [1:0]  EX_MEM_Size,
  input  logic        EX_MEM_SignExt,
  input  logic        EX_MEM_RegWrite,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBe,
  input  logic        MemAck,
  input  logic [31:0] MemRData,
  output logic [31:0] MemoryToRegisterMux,
  output logic        MEM_RegWrite,
  output logic        Stall,
  output logic        MisalignExc,
  output logic        BusErr
);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e            state_q, state_d;
  logic [31:0]       cap_data_q, cap_data_d;
  logic              fault_q, fault_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic        access;
  logic        misaligned;
  logic [1:0]  addr_lo;
  logic [31:0] rdata_shifted;
  logic [15:0] rdata_half;
  logic [31:0] load_data;

  assign addr_lo    = EX_MEM_ALUResult[1:0];
  assign access     = EX_MEM_MemRead | EX_MEM_MemWrite;
  assign misaligned = ((EX_MEM_Size == 2'b01) & addr_lo[0]) |
                      (EX_MEM_Size[1] & (addr_lo != 2'b00));

  // Byte lane moved down to bits [7:0]; half lane picked by addr[1].
  assign rdata_shifted = MemRData >> {addr_lo, 3'b000};
  assign rdata_half    = addr_lo[1] ? MemRData[31:16] : MemRData[15:0];

  always_comb begin
    load_data = MemRData;
    case (EX_MEM_Size)
      2'b00:   load_data = {{24{EX_MEM_SignExt & rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'b01:   load_data = {{16{EX_MEM_SignExt & rdata_half[15]}}, rdata_half};
      default: load_data = MemRData;
    endcase
  end

  // Request-side address/data/enables depend only on the (held) EX_MEM fields,
  // so they stay stable for the whole time MemReq is asserted.
  assign MemAddr = {EX_MEM_ALUResult[31:2], 2'b00};

  always_comb begin
    MemWData = EX_MEM_WriteData;
    MemBe    = 4'b1111;
    if (EX_MEM_MemWrite) begin
      case (EX_MEM_Size)
        2'b00: begin
          MemWData = {4{EX_MEM_WriteData[7:0]}};
          MemBe    = 4'b0001 << addr_lo;
        end
        2'b01: begin
          MemWData = {2{EX_MEM_WriteData[15:0]}};
          MemBe    = addr_lo[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          MemWData = EX_MEM_WriteData;
          MemBe    = 4'b1111;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q    <= StIdle;
      cap_data_q <= 32'h0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      cap_data_q <= cap_data_d;
      fault_q    <= fault_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next-state logic. cnt_q holds the number of request cycles already spent,
  // so the current WAIT cycle is request cycle cnt_q+1; the timeout fires on
  // request cycle TIMEOUT, giving exactly TIMEOUT stall cycles.
  always_comb begin
    state_d    = state_q;
    cap_data_d = cap_data_q;
    fault_d    = fault_q;
    cnt_d      = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (access && !misaligned) begin
          cnt_d = CNT_W'(1);
          if (MemAck) begin
            state_d    = StDone;
            cap_data_d = EX_MEM_MemRead ? load_data : 32'h0;
            fault_d    = 1'b0;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (MemAck) begin
          state_d    = StDone;
          cap_data_d = EX_MEM_MemRead ? load_data : 32'h0;
          fault_d    = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d    = StDone;
          cap_data_d = 32'h0;
          fault_d    = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs. Everything visible to the pipeline is forced low while in reset,
  // which also drops a request abandoned by a reset in WAIT.
  always_comb begin
    MemReq              = 1'b0;
    Stall               = 1'b0;
    MEM_RegWrite        = 1'b0;
    MisalignExc         = 1'b0;
    BusErr              = 1'b0;
    MemoryToRegisterMux = 32'h0;
    if (Rst) begin
      unique case (state_q)
        StIdle: begin
          MemoryToRegisterMux = EX_MEM_ALUResult;
          if (!access) begin
            MEM_RegWrite = EX_MEM_RegWrite;
          end else if (misaligned) begin
            MisalignExc = 1'b1;
          end else begin
            MemReq = 1'b1;
            Stall  = 1'b1;
          end
        end
        StWait: begin
          MemoryToRegisterMux = EX_MEM_ALUResult;
          MemReq              = 1'b1;
          Stall               = 1'b1;
        end
        StDone: begin
          MemoryToRegisterMux = EX_MEM_MemRead ? cap_data_q : EX_MEM_ALUResult;
          MEM_RegWrite        = EX_MEM_RegWrite & ~fault_q;
          BusErr              = fault_q;
        end
        default: begin
          MemoryToRegisterMux = 32'h0;
        end
      endcase
    end
  end

  assign MemWe = MemReq & EX_MEM_MemWrite;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        Clk;
  logic        Rst;
  logic [31:0] EX_MEM_ALUResult;
  logic [31:0] EX_MEM_WriteData;
  logic        EX_MEM_MemRead;
  logic        EX_MEM_MemWrite;
  logic [1:0]  EX_MEM_Size;
  logic        EX_MEM_SignExt;
  logic        EX_MEM_RegWrite;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [3:0]  MemBe;
  logic        MemAck;
  logic [31:0] MemRData;
  logic [31:0] MemoryToRegisterMux;
  logic        MEM_RegWrite;
  logic        Stall;
  logic        MisalignExc;
  logic        BusErr;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_stage #(
    .TIMEOUT(4),
    .CNT_W  (3)
  ) dut (
    .Clk                (Clk),
    .Rst                (Rst),
    .EX_MEM_ALUResult   (EX_MEM_ALUResult),
    .EX_MEM_WriteData   (EX_MEM_WriteData),
    .EX_MEM_MemRead     (EX_MEM_MemRead),
    .EX_MEM_MemWrite    (EX_MEM_MemWrite),
    .EX_MEM_Size        (EX_MEM_Size),
    .EX_MEM_SignExt     (EX_MEM_SignExt),
    .EX_MEM_RegWrite    (EX_MEM_RegWrite),
    .MemReq             (MemReq),
    .MemWe              (MemWe),
    .MemAddr            (MemAddr),
    .MemWData           (MemWData),
    .MemBe              (MemBe),
    .MemAck             (MemAck),
    .MemRData           (MemRData),
    .MemoryToRegisterMux(MemoryToRegisterMux),
    .MEM_RegWrite       (MEM_RegWrite),
    .Stall              (Stall),
    .MisalignExc        (MisalignExc),
    .BusErr             (BusErr)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Inputs are driven at the falling edge and checked 1 time unit later.
  task automatic set_op(input logic [31:0] alu, input logic [31:0] wd, input logic rd,
                        input logic wr, input logic [1:0] sz, input logic sx,
                        input logic rw);
    EX_MEM_ALUResult = alu;
    EX_MEM_WriteData = wd;
    EX_MEM_MemRead   = rd;
    EX_MEM_MemWrite  = wr;
    EX_MEM_Size      = sz;
    EX_MEM_SignExt   = sx;
    EX_MEM_RegWrite  = rw;
  endtask

  task automatic next_cycle();
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    set_op(32'h0000_5555, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
    MemAck = 1'b0;
    next_cycle();
    next_cycle();
    #1;
    n_tests++;
    if (MemReq !== 1'b0) begin
      $display("FAIL reset_memreq: got %b expected 0", MemReq); n_fail++;
    end
    n_tests++;
    if (Stall !== 1'b0) begin
      $display("FAIL reset_stall: got %b expected 0", Stall); n_fail++;
    end
    n_tests++;
    if (MEM_RegWrite !== 1'b0) begin
      $display("FAIL reset_regwrite: got %b expected 0", MEM_RegWrite); n_fail++;
    end
    n_tests++;
    if (MemoryToRegisterMux !== 32'h0) begin
      $display("FAIL reset_mux: got %h expected 00000000", MemoryToRegisterMux); n_fail++;
    end
    next_cycle();
    Rst = 1'b1;
    set_op(32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    next_cycle();
  endtask

  task automatic test_alu_passthrough();
    set_op(32'h0000_1234, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1);
    #1;
    n_tests++;
    if (MemoryToRegisterMux !== 32'h0000_1234) begin
      $display("FAIL alu_mux: got %h expected 00001234", MemoryToRegisterMux); n_fail++;
    end
    n_tests++;
    if (MEM_RegWrite !== 1'b1) begin
      $display("FAIL alu_regwrite: got %b expected 1", MEM_RegWrite); n_fail++;
    end
    n_tests++;
    if (Stall !== 1'b0 || MemReq !== 1'b0) begin
      $display("FAIL alu_stall: got stall=%b req=%b expected 0 0", Stall, MemReq); n_fail++;
    end
    next_cycle();
  endtask

  task automatic test_word_load();
    set_op(32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
    MemRData = 32'h0;
    for (int c = 1; c <= 3; c++) begin
      MemAck   = (c == 3);
      MemRData = (c == 3) ? 32'hDEAD_BEEF : 32'h0;
      #1;
      n_tests++;
      if (Stall !== 1'b1 || MemReq !== 1'b1 || MEM_RegWrite !== 1'b0) begin
        $display("FAIL wload_wait_c%0d: got stall=%b req=%b rw=%b expected 1 1 0",
                 c, Stall, MemReq, MEM_RegWrite);
        n_fail++;
      end
      if (c == 1) begin
        n_tests++;
        if (MemAddr !== 32'h100 || MemBe !== 4'b1111 || MemWe !== 1'b0) begin
          $display("FAIL wload_req: got addr=%h be=%b we=%b expected 00000100 1111 0",
                   MemAddr, MemBe, MemWe);
          n_fail++;
        end
      end
      next_cycle();
    end
    MemAck = 1'b0;
    #1;
    n_tests++;
    if (Stall !== 1'b0 || MemReq !== 1'b0) begin
      $display("FAIL wload_done_stall: got stall=%b req=%b expected 0 0", Stall, MemReq);
      n_fail++;
    end
    n_tests++;
    if (MemoryToRegisterMux !== 32'hDEAD_BEEF || MEM_RegWrite !== 1'b1) begin
      $display("FAIL wload_done_data: got %h rw=%b expected deadbeef 1",
               MemoryToRegisterMux, MEM_RegWrite);
      n_fail++;
    end
    next_cycle();
  endtask

  task automatic test_byte_load();
    // Signed byte at lane 3 with immediate ack.
    set_op(32'h0000_0103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1);
    MemAck   = 1'b1;
    MemRData = 32'h80FF_0000;
    #1;
    n_tests++;
    if (Stall !== 1'b1) begin
      $display("FAIL sbyte_stall: got %b expected 1", Stall); n_fail++;
    end
    next_cycle();
    MemAck = 1'b0;
    #1;
    n_tests++;
    if (MemoryToRegisterMux !== 32'hFFFF_FF80 || MEM_RegWrite !== 1'b1) begin
      $display("FAIL sbyte_data: got %h rw=%b expected ffffff80 1",
               MemoryToRegisterMux, MEM_RegWrite);
      n_fail++;
    end
    next_cycle();
    // Same access, zero-extended.
    set_op(32'h0000_0103, 32'h0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1);
    MemAck = 1'b1;
    next_cycle();
    MemAck = 1'b0;
    #1;
    n_tests++;
    if (MemoryToRegisterMux !== 32'h0000_0080) begin
      $display("FAIL ubyte_data: got %h expected 00000080", MemoryToRegisterMux); n_fail++;
    end
    next_cycle();
    // Signed half from the upper lane.
    set_op(32'h0000_0106, 32'h0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1);
    MemAck   = 1'b1;
    MemRData = 32'h9234_5678;
    next_cycle();
    MemAck = 1'b0;
    #1;
    n_tests++;
    if (MemoryToRegisterMux !== 32'hFFFF_9234) begin
      $display("FAIL shalf_data: got %h expected ffff9234", MemoryToRegisterMux); n_fail++;
    end
    next_cycle();
  endtask

  task automatic test_stores();
    set_op(32'h0000_0202, 32'h0000_ABCD, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0);
    MemAck = 1'b1;
    #1;
    n_tests++;
    if (MemAddr !== 32'h200 || MemBe !== 4'b1100 || MemWData !== 32'hABCD_ABCD ||
        MemWe !== 1'b1) begin
      $display("FAIL hstore_req: got addr=%h be=%b wd=%h we=%b expected 00000200 1100 abcdabcd 1",
               MemAddr, MemBe, MemWData, MemWe);
      n_fail++;
    end
    next_cycle();
    MemAck = 1'b0;
    #1;
    n_tests++;
    if (MEM_RegWrite !== 1'b0 || Stall !== 1'b0 || MemoryToRegisterMux !== 32'h202) begin
      $display("FAIL hstore_done: got rw=%b stall=%b mux=%h expected 0 0 00000202",
               MEM_RegWrite, Stall, MemoryToRegisterMux);
      n_fail++;
    end
    next_cycle();
    set_op(32'h0000_0201, 32'h1234_565A, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    MemAck = 1'b1;
    #1;
    n_tests++;
    if (MemBe !== 4'b0010 || MemWData !== 32'h5A5A_5A5A) begin
      $display("FAIL bstore_req: got be=%b wd=%h expected 0010 5a5a5a5a", MemBe, MemWData);
      n_fail++;
    end
    next_cycle();
    MemAck = 1'b0;
    next_cycle();
  endtask

  task automatic test_misalign();
    set_op(32'h0000_0101, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
    #1;
    n_tests++;
    if (MisalignExc !== 1'b1 || MemReq !== 1'b0 || Stall !== 1'b0 || MEM_RegWrite !== 1'b0) begin
      $display("FAIL misalign: got exc=%b req=%b stall=%b rw=%b expected 1 0 0 0",
               MisalignExc, MemReq, Stall, MEM_RegWrite);
      n_fail++;
    end
    next_cycle();
    set_op(32'h0000_0010, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1);
    #1;
    n_tests++;
    if (MisalignExc !== 1'b0 || MEM_RegWrite !== 1'b1) begin
      $display("FAIL misalign_clear: got exc=%b rw=%b expected 0 1", MisalignExc, MEM_RegWrite);
      n_fail++;
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    int stalls;
    stalls = 0;
    set_op(32'h0000_0300, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
    MemAck = 1'b0;
    #1;
    while (Stall === 1'b1 && stalls < 10) begin
      stalls++;
      next_cycle();
      #1;
    end
    n_tests++;
    if (stalls !== 4) begin
      $display("FAIL timeout_stalls: got %0d expected 4", stalls); n_fail++;
    end
    n_tests++;
    if (BusErr !== 1'b1 || MemoryToRegisterMux !== 32'h0 || MEM_RegWrite !== 1'b0 ||
        MemReq !== 1'b0) begin
      $display("FAIL timeout_done: got buserr=%b mux=%h rw=%b req=%b expected 1 00000000 0 0",
               BusErr, MemoryToRegisterMux, MEM_RegWrite, MemReq);
      n_fail++;
    end
    next_cycle();
    set_op(32'h0000_0020, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1);
    #1;
    n_tests++;
    if (BusErr !== 1'b0) begin
      $display("FAIL timeout_buserr_clear: got %b expected 0", BusErr); n_fail++;
    end
    next_cycle();
  endtask

  task automatic test_reset_in_wait();
    set_op(32'h0000_0400, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
    MemAck = 1'b0;
    next_cycle();
    next_cycle();
    Rst = 1'b0;
    #1;
    n_tests++;
    if (MemReq !== 1'b0 || Stall !== 1'b0) begin
      $display("FAIL rstwait_req: got req=%b stall=%b expected 0 0", MemReq, Stall); n_fail++;
    end
    next_cycle();
    Rst = 1'b1;
    set_op(32'h0000_0044, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
    MemAck   = 1'b1;
    MemRData = 32'hFFFF_FFFF;
    #1;
    n_tests++;
    if (MemReq !== 1'b0 || Stall !== 1'b0 || MEM_RegWrite !== 1'b0 ||
        MemoryToRegisterMux !== 32'h44) begin
      $display("FAIL rstwait_late_ack: got req=%b stall=%b rw=%b mux=%h expected 0 0 0 00000044",
               MemReq, Stall, MEM_RegWrite, MemoryToRegisterMux);
      n_fail++;
    end
    next_cycle();
    set_op(32'h0000_0500, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1);
    MemAck   = 1'b1;
    MemRData = 32'h1234_5678;
    #1;
    n_tests++;
    if (MemReq !== 1'b1 || Stall !== 1'b1) begin
      $display("FAIL rstwait_new_req: got req=%b stall=%b expected 1 1", MemReq, Stall);
      n_fail++;
    end
    next_cycle();
    MemAck = 1'b0;
    #1;
    n_tests++;
    if (MemoryToRegisterMux !== 32'h1234_5678 || MEM_RegWrite !== 1'b1 || BusErr !== 1'b0) begin
      $display("FAIL rstwait_new_done: got %h rw=%b buserr=%b expected 12345678 1 0",
               MemoryToRegisterMux, MEM_RegWrite, BusErr);
      n_fail++;
    end
    next_cycle();
    set_op(32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  initial begin
    Rst      = 1'b0;
    MemAck   = 1'b0;
    MemRData = 32'h0;
    set_op(32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    @(negedge Clk);
    test_reset();
    test_alu_passthrough();
    test_word_load();
    test_byte_load();
    test_stores();
    test_misalign();
    test_timeout();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Data-memory access stage of the pipelined MIPS core, between the EX_MEM pipeline register and the MEM_WB pipeline register. It performs loads and stores against a variable-latency data memory over a req/ack handshake, with byte, halfword and word sizes. It stalls the upstream pipeline while an access is outstanding. It drives the write-back value and a bubble-qualified RegWrite into MEM_WB.

## Interface
- TIMEOUT, 64, maximum cycles to wait for MemAck before aborting (≥2)
- CNT_W, 7, width of the wait counter (must hold TIMEOUT)

Ports:
- Clk  in  1  clock, all state updates on posedge
- Rst  in  1  reset, synchronous, active-low
- EX_MEM_ALUResult  in  32  effective address, or ALU result for non-memory ops
- EX_MEM_WriteData  in  32  store data (right-aligned)
- EX_MEM_MemRead  in  1  load
- EX_MEM_MemWrite  in  1  store (MemRead and MemWrite never both 1)
- EX_MEM_Size  in  2  00 byte, 01 half, 10 word, 11 treated as word
- EX_MEM_SignExt  in  1  sign-extend sub-word loads
- EX_MEM_RegWrite  in  1  instruction writes the register file
- MemReq  out  1  memory request
- MemWe  out  1  1 = store
- MemAddr  out  32  word-aligned address ({addr[31:2],2'b00})
- MemWData  out  32  lane-replicated store data
- MemBe  out  4  byte enables, bit i = byte lane i (little-endian)
- MemAck  in  1  memory completion; MemRData valid in the same cycle for loads
- MemRData  in  32  read data
- MemoryToRegisterMux  out  32  write-back value to MEM_WB
- MEM_RegWrite  out  1  RegWrite to MEM_WB, forced 0 on bubbles and faults
- Stall  out  1  freeze PC/IF_ID/ID_EX/EX_MEM this cycle
- MisalignExc  out  1  one-cycle misaligned-access flag
- BusErr  out  1  one-cycle timeout flag

## Operation
- Access = MemRead | MemWrite. Misaligned = (Size=01 & addr[0]) | (Size≥10 & addr[1:0]≠0).
- The FSM has three states: IDLE, WAIT, DONE. Registers are state, CapData[31:0], Fault, and Cnt[CNT_W-1:0].
- IDLE, no access: MemoryToRegisterMux = ALUResult; MEM_RegWrite = EX_MEM_RegWrite; Stall = 0; no request.
- IDLE, misaligned access:
  - No request and no stall.
  - MisalignExc = 1 and MEM_RegWrite = 0.
  - Stay in IDLE.
- IDLE, aligned access:
  - MemReq = 1 and Stall = 1; Cnt ← 1.
  - If MemAck = 1, capture and go to DONE. Otherwise go to WAIT.
- WAIT:
  - MemReq = 1, Stall = 1, Cnt ← Cnt+1.
  - If MemAck = 1, capture and go to DONE (Fault ← 0).
  - Otherwise, if Cnt = TIMEOUT, go to DONE with Fault ← 1 and CapData ← 0. MemReq drops in DONE.
- Capture (loads): select the lane by addr[1:0] (half lanes by addr[1]), then zero- or sign-extend per SignExt into CapData. Stores capture 0.
- DONE:
  - Stall = 0, MemReq = 0.
  - MemoryToRegisterMux = MemRead ? CapData : ALUResult.
  - MEM_RegWrite = EX_MEM_RegWrite & ~Fault.
  - BusErr = Fault.
  - Next state is IDLE.
- While Stall = 1, MEM_RegWrite = 0, so MEM_WB receives a bubble each stall cycle.
- Store lanes:
  - Byte: MemWData = {4{wd[7:0]}}, MemBe = 0001 << addr[1:0].
  - Half: MemWData = {2{wd[15:0]}}, MemBe = addr[1] ? 1100 : 0011.
  - Word: MemWData = wd, MemBe = 1111.
- Loads drive MemBe = 1111. MemWe = MemWrite whenever MemReq = 1, else 0.
- MemAck while MemReq = 0 is ignored.

## Timing
- Rst low at a clock edge sets state = IDLE, CapData = 0, Fault = 0, Cnt = 0.
- While Rst is low, these outputs are 0: MemReq, Stall, MEM_RegWrite, MisalignExc, BusErr, MemoryToRegisterMux.
- Reset in WAIT abandons the access: MemReq is 0 from the reset cycle onward, and no write-back occurs.
- Latency:
  - Non-memory ops take 0 extra cycles.
  - A memory op whose ack arrives on its first cycle takes 2 cycles (IDLE+DONE), i.e. 1 stall cycle.
  - Ack on cycle k gives k stall cycles.
  - A timeout gives TIMEOUT stall cycles, then the DONE cycle.
- EX_MEM is held by Stall, so its inputs are stable from IDLE through DONE. The next instruction is seen in IDLE on the cycle after DONE.
- MemReq is held continuously until the ack cycle; address, data and Be are stable for that whole time.

## Test plan
- Add result 0x0000_1234, RegWrite=1, no access -> same cycle MemoryToRegisterMux=0x1234, MEM_RegWrite=1, Stall=0.
- Word load at 0x100, ack on 3rd request cycle, RData 0xDEADBEEF -> Stall high 3 cycles with MEM_RegWrite=0, then DONE outputs 0xDEADBEEF with MEM_RegWrite=1.
- Signed byte load at 0x103, RData 0x80FF_0000, ack immediately -> 0xFFFF_FF80; unsigned -> 0x0000_0080.
- Half store 0xABCD at 0x202 -> MemAddr=0x200, MemBe=1100, MemWData=0xABCDABCD, MemWe=1.
- Word load at 0x101 -> MisalignExc=1 for 1 cycle, no MemReq, MEM_RegWrite=0. Separately, no ack for TIMEOUT=4 -> 4 stall cycles, then BusErr=1, data 0, MEM_RegWrite=0.
- Rst low during WAIT -> next cycle MemReq=0, Stall=0. A late MemAck is ignored, and the next access starts cleanly from IDLE.
